// File: rtl/bcd2bin_16.sv
// rtl/bcd2bin_16.sv - sequential BCD-to-binary converter (reverse double-dabble), optional saturation via BCD2BIN_SAT_EN
module bcd2bin_16 #(
    parameter int NDIG  = 5,
    parameter int OUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  bin,
    output logic              ovf,
    output logic              err
);
    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   bcd_q, acc_q, bcd_nx, acc_nx;
    logic [W-1:0]   bcd_sh, acc_sh;
    logic [CW-1:0]  cnt_q, cnt_nx;
    logic           err_q, err_nx;
    logic           in_bad;
    logic           acc_big;
    logic [OUT_W-1:0] bin_res;

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
    end

    // One right shift of {bcd, acc}, then every digit that landed at >= 8 drops by 3.
    always_comb begin
        {bcd_sh, acc_sh} = {bcd_q, acc_q} >> 1;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd8) bcd_sh[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
        end
    end

    assign acc_big = (acc_q >> OUT_W) != '0;

`ifdef BCD2BIN_SAT_EN
    assign bin_res = acc_big ? {OUT_W{1'b1}} : acc_q[OUT_W-1:0];
`else
    assign bin_res = acc_q[OUT_W-1:0];
`endif

    always_comb begin
        state_nx = state;
        bcd_nx   = bcd_q;
        acc_nx   = acc_q;
        cnt_nx   = cnt_q;
        err_nx   = err_q;
        case (state)
            IDLE: begin
                if (start) begin
                    bcd_nx   = bcd_in;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    err_nx   = in_bad;
                    state_nx = in_bad ? FIN : SHIFT;
                end
            end
            SHIFT: begin
                bcd_nx = bcd_sh;
                acc_nx = acc_sh;
                cnt_nx = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) state_nx = FIN;
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == SHIFT) || (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bcd_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            bcd_q <= bcd_nx;
            acc_q <= acc_nx;
            cnt_q <= cnt_nx;
            err_q <= err_nx;
            done  <= (state == FIN);
            if (state == FIN) begin
                bin <= err_q ? '0 : bin_res;
                ovf <= err_q ? 1'b0 : acc_big;
                err <= err_q;
            end
        end
    end
endmodule
